// File: rtl/rdmx_tx_arbiter_if.sv
// AXI-Stream bundle for the RDMX TX arbiter: NUM_INPUTS packed source streams in, one merged MAC stream out.
// "slave" is the arbiter's view; "master" is the view of the sources and MAC around it.
interface rdmx_tx_arbiter_if #(
   parameter int DATA_WBITS = 512,
   parameter int NUM_INPUTS = 4
);
   localparam int KEEP_WBITS = DATA_WBITS / 8;

   logic [NUM_INPUTS*DATA_WBITS-1:0] S_AXIS_TDATA;
   logic [NUM_INPUTS*KEEP_WBITS-1:0] S_AXIS_TKEEP;
   logic [NUM_INPUTS-1:0]            S_AXIS_TLAST;
   logic [NUM_INPUTS-1:0]            S_AXIS_TVALID;
   logic [NUM_INPUTS-1:0]            S_AXIS_TREADY;

   logic [DATA_WBITS-1:0]            AXIS_TX_TDATA;
   logic [KEEP_WBITS-1:0]            AXIS_TX_TKEEP;
   logic                             AXIS_TX_TLAST;
   logic                             AXIS_TX_TVALID;
   logic                             AXIS_TX_TREADY;

   modport master (
      output S_AXIS_TDATA, S_AXIS_TKEEP, S_AXIS_TLAST, S_AXIS_TVALID, AXIS_TX_TREADY,
      input  S_AXIS_TREADY, AXIS_TX_TDATA, AXIS_TX_TKEEP, AXIS_TX_TLAST, AXIS_TX_TVALID
   );

   modport slave (
      input  S_AXIS_TDATA, S_AXIS_TKEEP, S_AXIS_TLAST, S_AXIS_TVALID, AXIS_TX_TREADY,
      output S_AXIS_TREADY, AXIS_TX_TDATA, AXIS_TX_TKEEP, AXIS_TX_TLAST, AXIS_TX_TVALID
   );
endinterface

// File: rtl/rdmx_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one Ethernet AXI-Stream TX port among NUM_INPUTS sources.
// Optional per-input completed-packet counters are built when RDMX_TX_ARB_PKT_COUNT_EN is defined.
module rdmx_tx_arbiter #(
   parameter int DATA_WBITS  = 512,
   parameter int NUM_INPUTS  = 4,
   parameter int GRANT_WBITS = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_INPUTS-1:0]    enable_mask,
   rdmx_tx_arbiter_if.slave         bus,
   output logic [GRANT_WBITS-1:0]   grant_idx,
   output logic                     busy
`ifdef RDMX_TX_ARB_PKT_COUNT_EN
   ,
   output logic [NUM_INPUTS*32-1:0] pkt_count
`endif
);

   localparam int KEEP_WBITS = DATA_WBITS / 8;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [GRANT_WBITS-1:0] grant_q, grant_d;
   logic [GRANT_WBITS-1:0] rr_sel;
   logic                   rr_found;
   logic [NUM_INPUTS-1:0]  req;

   logic [DATA_WBITS-1:0]  tx_data;
   logic [KEEP_WBITS-1:0]  tx_keep;
   logic                   tx_last;
   logic                   tx_valid;
   logic [NUM_INPUTS-1:0]  s_ready;
   logic                   pkt_done;

   assign req = bus.S_AXIS_TVALID & enable_mask;

   // Round-robin pick: the first requester after the last grant, wrapping modulo NUM_INPUTS.
   always_comb begin
      rr_found = 1'b0;
      rr_sel   = grant_q;
      for (int k = 1; k <= NUM_INPUTS; k++) begin
         for (int i = 0; i < NUM_INPUTS; i++) begin
            if (!rr_found && req[i] && (i == (int'(grant_q) + k) % NUM_INPUTS)) begin
               rr_found = 1'b1;
               rr_sel   = GRANT_WBITS'(i);
            end
         end
      end
   end

   // Zero-latency pass-through of the granted input; gated off in IDLE and while reset is high.
   always_comb begin
      tx_data  = '0;
      tx_keep  = '0;
      tx_last  = 1'b0;
      tx_valid = 1'b0;
      s_ready  = '0;
      if (state_q == SEND && !reset) begin
         for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant_q == GRANT_WBITS'(i)) begin
               tx_data    = bus.S_AXIS_TDATA[i*DATA_WBITS +: DATA_WBITS];
               tx_keep    = bus.S_AXIS_TKEEP[i*KEEP_WBITS +: KEEP_WBITS];
               tx_last    = bus.S_AXIS_TLAST[i];
               tx_valid   = bus.S_AXIS_TVALID[i];
               s_ready[i] = bus.AXIS_TX_TREADY;
            end
         end
      end
   end

   assign pkt_done = tx_valid & bus.AXIS_TX_TREADY & tx_last;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      case (state_q)
         IDLE: begin
            if (rr_found) begin
               state_d = SEND;
               grant_d = rr_sel;
            end
         end
         SEND: begin
            if (pkt_done) begin
               state_d = IDLE;
            end
         end
      endcase
   end

   // Reset points the grant at the last input so input 0 wins the first arbitration.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= GRANT_WBITS'(NUM_INPUTS - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
      end
   end

   assign bus.AXIS_TX_TDATA  = tx_data;
   assign bus.AXIS_TX_TKEEP  = tx_keep;
   assign bus.AXIS_TX_TLAST  = tx_last;
   assign bus.AXIS_TX_TVALID = tx_valid;
   assign bus.S_AXIS_TREADY  = s_ready;
   assign grant_idx          = grant_q;
   assign busy               = (state_q == SEND);

`ifdef RDMX_TX_ARB_PKT_COUNT_EN
   logic [31:0] pkt_cnt_q [NUM_INPUTS];

   // Counts TLAST handshakes per input; wraps naturally at 2**32.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_INPUTS; i++) begin
            pkt_cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_INPUTS; i++) begin
            if (pkt_done && grant_q == GRANT_WBITS'(i)) begin
               pkt_cnt_q[i] <= pkt_cnt_q[i] + 32'd1;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_cnt
      assign pkt_count[g*32 +: 32] = pkt_cnt_q[g];
   end
`endif

endmodule

// File: tb/tb_rdmx_tx_arbiter.sv
// Scoreboard bench for rdmx_tx_arbiter: sources replay directed packets, a monitor pops hand-ordered expected beats.
module tb_rdmx_tx_arbiter;

   localparam int DW = 512;
   localparam int NI = 4;
   localparam int GW = 3;
   localparam int KW = DW / 8;

   typedef struct {
      int            src;
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
   } beat_t;

   logic          clk;
   logic          reset;
   logic [NI-1:0] enable_mask;
   logic [GW-1:0] grant_idx;
   logic          busy;
`ifdef RDMX_TX_ARB_PKT_COUNT_EN
   logic [NI*32-1:0] pkt_count;
`endif

   rdmx_tx_arbiter_if #(.DATA_WBITS(DW), .NUM_INPUTS(NI)) bus ();

   rdmx_tx_arbiter #(.DATA_WBITS(DW), .NUM_INPUTS(NI), .GRANT_WBITS(GW)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable_mask (enable_mask),
      .bus         (bus),
      .grant_idx   (grant_idx),
      .busy        (busy)
`ifdef RDMX_TX_ARB_PKT_COUNT_EN
      ,
      .pkt_count   (pkt_count)
`endif
   );

   beat_t srcq [NI][$];
   beat_t expq [$];
   int    popCount [NI];
   int    gapAt [NI];
   int    gapLen [NI];
   int    gapLeft [NI];
   bit    readyMode = 0;
   int    total = 0;
   int    bad = 0;
   int    cyc = 0;
   int    beatsSeen = 0;
   int    firstCyc = 0;
   int    lastCyc = 0;
   int    prevCyc = 0;
   bit    prevLast = 1;
   bit    havePrev = 0;
   bit    checkGap = 0;
   bit    watch3 = 0;
   bit    leak3 = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] beatData(input int src, input int pkt, input int beat);
      logic [DW-1:0] d;
      logic [31:0]   w;
      w = {8'hC0, src[7:0], pkt[7:0], beat[7:0]};
      for (int j = 0; j < DW / 32; j++) d[j*32 +: 32] = w ^ (32'(j) << 20);
      return d;
   endfunction

   function automatic logic [KW-1:0] beatKeep(input int beat, input bit last);
      logic [KW-1:0] k;
      k = '1;
      if (last) k = k >> beat;
      return k;
   endfunction

   task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input int src, input int pkt, input int nBeats);
      beat_t b;
      for (int k = 1; k <= nBeats; k++) begin
         b.src  = src;
         b.last = (k == nBeats);
         b.data = beatData(src, pkt, k);
         b.keep = beatKeep(k, b.last);
         srcq[src].push_back(b);
      end
   endtask

   task automatic expectBeats(input int src, input int pkt, input int fromBeat, input int toBeat, input int nBeats);
      beat_t b;
      for (int k = fromBeat; k <= toBeat; k++) begin
         b.src  = src;
         b.last = (k == nBeats);
         b.data = beatData(src, pkt, k);
         b.keep = beatKeep(k, b.last);
         expq.push_back(b);
      end
   endtask

   task automatic resetDut();
      @(negedge clk);
      reset = 1'b1;
      enable_mask = '1;
      for (int i = 0; i < NI; i++) begin
         srcq[i].delete();
         popCount[i] = 0;
         gapAt[i]    = 0;
         gapLen[i]   = 0;
         gapLeft[i]  = 0;
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic waitDrain(input string name, input int budget);
      int n;
      n = 0;
      while ((expq.size() != 0 || busy) && n < budget) begin
         @(negedge clk);
         #2;
         n++;
      end
      checkOutput(name, DW'(expq.size() != 0 || busy), '0);
   endtask

   task automatic waitBeats(input string name, input int count, input int budget);
      int n;
      n = 0;
      while (beatsSeen < count && n < budget) begin
         @(negedge clk);
         #2;
         n++;
      end
      checkOutput(name, DW'(beatsSeen >= count), DW'(1));
   endtask

   // Source/MAC driver: inputs change 1 time unit after the rising edge.
   initial begin : driver
      logic [NI-1:0] fireS;
      bus.S_AXIS_TDATA   = '0;
      bus.S_AXIS_TKEEP   = '0;
      bus.S_AXIS_TLAST   = '0;
      bus.S_AXIS_TVALID  = '0;
      bus.AXIS_TX_TREADY = 1'b1;
      forever begin
         @(negedge clk);
         fireS = bus.S_AXIS_TVALID & bus.S_AXIS_TREADY;
         @(posedge clk);
         #1;
         for (int i = 0; i < NI; i++) begin
            if (fireS[i] && srcq[i].size() > 0) begin
               void'(srcq[i].pop_front());
               popCount[i]++;
               if (popCount[i] == gapAt[i]) gapLeft[i] = gapLen[i];
            end
            if (gapLeft[i] > 0) begin
               bus.S_AXIS_TVALID[i] = 1'b0;
               gapLeft[i]--;
            end else if (srcq[i].size() > 0) begin
               bus.S_AXIS_TVALID[i]            = 1'b1;
               bus.S_AXIS_TDATA[i*DW +: DW]    = srcq[i][0].data;
               bus.S_AXIS_TKEEP[i*KW +: KW]    = srcq[i][0].keep;
               bus.S_AXIS_TLAST[i]             = srcq[i][0].last;
            end else begin
               bus.S_AXIS_TVALID[i] = 1'b0;
            end
         end
         bus.AXIS_TX_TREADY = readyMode ? ~bus.AXIS_TX_TREADY : 1'b1;
      end
   end

   // Monitor: every output handshake must match the head of the expected queue.
   initial begin : monitor
      beat_t e;
      forever begin
         @(negedge clk);
         if (watch3 && bus.S_AXIS_TREADY[3] && expq.size() > 1) leak3 = 1'b1;
         if (bus.AXIS_TX_TVALID && bus.AXIS_TX_TREADY) begin
            if (expq.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_beat: got beat from grant_idx=%0d data=%0h, required no beat",
                        grant_idx, bus.AXIS_TX_TDATA[31:0]);
            end else begin
               e = expq.pop_front();
               checkOutput("tx_data", bus.AXIS_TX_TDATA, e.data);
               checkOutput("tx_keep", DW'(bus.AXIS_TX_TKEEP), DW'(e.keep));
               checkOutput("tx_last", DW'(bus.AXIS_TX_TLAST), DW'(e.last));
               checkOutput("grant_idx_beat", DW'(grant_idx), DW'(e.src));
               if (checkGap && havePrev && prevLast) checkOutput("idle_gap", DW'(cyc - prevCyc), DW'(2));
               prevLast = e.last;
               prevCyc  = cyc;
               havePrev = 1'b1;
            end
            beatsSeen++;
            if (beatsSeen == 1) firstCyc = cyc;
            lastCyc = cyc;
         end
      end
   end

   initial begin : main
      int pushCyc;
      reset = 1'b1;
      enable_mask = '1;
      for (int i = 0; i < NI; i++) begin
         popCount[i] = 0;
         gapAt[i]    = 0;
         gapLen[i]   = 0;
         gapLeft[i]  = 0;
      end
      repeat (3) @(negedge clk);
      checkOutput("rst_busy", DW'(busy), '0);
      checkOutput("rst_tvalid", DW'(bus.AXIS_TX_TVALID), '0);
      checkOutput("rst_s_tready", DW'(bus.S_AXIS_TREADY), '0);
      checkOutput("rst_grant", DW'(grant_idx), DW'(3));
      reset = 1'b0;

      $display("[TB] single 3-beat packet from input 2");
      resetDut();
      beatsSeen = 0;
      pushCyc = cyc;
      applyStimulus(2, 0, 3);
      expectBeats(2, 0, 1, 3, 3);
      waitDrain("drain_single", 50);
      checkOutput("first_beat_latency", DW'(firstCyc - pushCyc), DW'(2));
      checkOutput("last_beat_cycle", DW'(lastCyc - pushCyc), DW'(4));
      checkOutput("t1_grant", DW'(grant_idx), DW'(2));
      checkOutput("t1_busy", DW'(busy), '0);

      $display("[TB] four inputs requesting 2-beat packets");
      resetDut();
      havePrev = 1'b0;
      checkGap = 1'b1;
      applyStimulus(0, 0, 2); applyStimulus(0, 1, 2);
      applyStimulus(1, 0, 2); applyStimulus(1, 1, 2);
      applyStimulus(2, 0, 2); applyStimulus(3, 0, 2);
      expectBeats(0, 0, 1, 2, 2); expectBeats(1, 0, 1, 2, 2);
      expectBeats(2, 0, 1, 2, 2); expectBeats(3, 0, 1, 2, 2);
      expectBeats(0, 1, 1, 2, 2); expectBeats(1, 1, 1, 2, 2);
      waitDrain("drain_rr", 100);
      checkGap = 1'b0;
      checkOutput("t2_grant", DW'(grant_idx), DW'(1));

      $display("[TB] stalls and valid gaps hold the grant");
      resetDut();
      readyMode = 1'b1;
      gapAt[1] = 2;
      gapLen[1] = 2;
      leak3 = 1'b0;
      watch3 = 1'b1;
      applyStimulus(1, 0, 4);
      applyStimulus(3, 0, 1);
      expectBeats(1, 0, 1, 4, 4);
      expectBeats(3, 0, 1, 1, 1);
      waitDrain("drain_stall", 100);
      watch3 = 1'b0;
      readyMode = 1'b0;
      checkOutput("in3_ready_held", DW'(leak3), '0);
      checkOutput("t3_grant", DW'(grant_idx), DW'(3));

      $display("[TB] enable mask skips inputs");
      resetDut();
      enable_mask = 4'b1011;
      beatsSeen = 0;
      applyStimulus(0, 0, 2); applyStimulus(0, 1, 2);
      applyStimulus(1, 0, 3); applyStimulus(1, 1, 3);
      applyStimulus(2, 0, 1);
      applyStimulus(3, 0, 1);
      expectBeats(0, 0, 1, 2, 2);
      expectBeats(1, 0, 1, 3, 3);
      expectBeats(3, 0, 1, 1, 1);
      expectBeats(0, 1, 1, 2, 2);
      waitBeats("mask_wait_in1", 3, 50);
      enable_mask = 4'b1001;
      waitDrain("drain_mask", 100);
      repeat (8) @(negedge clk);
      checkOutput("t4_busy", DW'(busy), '0);
      checkOutput("t4_grant", DW'(grant_idx), DW'(0));

      $display("[TB] reset in the middle of a packet");
      resetDut();
      beatsSeen = 0;
      applyStimulus(1, 0, 5);
      expectBeats(1, 0, 1, 1, 5);
      expectBeats(0, 0, 1, 1, 1);
      expectBeats(1, 0, 2, 5, 5);
      waitBeats("rst_wait_beat1", 1, 50);
      @(posedge clk);
      #2;
      reset = 1'b1;
      applyStimulus(0, 0, 1);
      @(negedge clk);
      checkOutput("midrst_tvalid", DW'(bus.AXIS_TX_TVALID), '0);
      checkOutput("midrst_s_tready", DW'(bus.S_AXIS_TREADY), '0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      @(negedge clk);
      #2;
      checkOutput("postrst_busy", DW'(busy), '0);
      checkOutput("postrst_tvalid", DW'(bus.AXIS_TX_TVALID), '0);
      checkOutput("postrst_grant", DW'(grant_idx), DW'(3));
      waitDrain("drain_midrst", 100);

`ifdef RDMX_TX_ARB_PKT_COUNT_EN
      $display("[TB] packet counters");
      resetDut();
      for (int p = 0; p < 5; p++) applyStimulus(0, p, 1);
      applyStimulus(3, 0, 1);
      applyStimulus(3, 1, 1);
      expectBeats(0, 0, 1, 1, 1); expectBeats(3, 0, 1, 1, 1);
      expectBeats(0, 1, 1, 1, 1); expectBeats(3, 1, 1, 1, 1);
      expectBeats(0, 2, 1, 1, 1); expectBeats(0, 3, 1, 1, 1);
      expectBeats(0, 4, 1, 1, 1);
      waitDrain("drain_cnt", 100);
      @(negedge clk);
      checkOutput("cnt0", DW'(pkt_count[0 +: 32]), DW'(5));
      checkOutput("cnt1", DW'(pkt_count[32 +: 32]), DW'(0));
      checkOutput("cnt2", DW'(pkt_count[64 +: 32]), DW'(0));
      checkOutput("cnt3", DW'(pkt_count[96 +: 32]), DW'(2));
      dut.pkt_cnt_q[3] = 32'hFFFF_FFFF;
      applyStimulus(3, 2, 1);
      expectBeats(3, 2, 1, 1, 1);
      waitDrain("drain_wrap", 50);
      @(negedge clk);
      checkOutput("cnt3_wrap", DW'(pkt_count[96 +: 32]), DW'(0));
      checkOutput("cnt0_hold", DW'(pkt_count[0 +: 32]), DW'(5));
`endif

      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rdmx_tx_arbiter.md
Name: rdmx_tx_arbiter

Overview:
- Shares one outgoing Ethernet AXI-Stream transmit port among NUM_INPUTS packet sources, e.g. several RDMX transmit engines or an RDMX engine plus a control/ping packet source.
- Arbitration is round-robin at packet granularity. A grant is held from the first beat of a packet to its TLAST handshake, so packets never interleave.
- Sits between the RDMX transmit back-ends and the Ethernet MAC TX interface, in the MAC clock domain.

Parameters:
- DATA_WBITS, 512, width of TDATA in bits. TKEEP is DATA_WBITS/8.
- NUM_INPUTS, 4, number of requesting streams, 2..8.
- GRANT_WBITS, 3, width of the grant index. Must satisfy 2**GRANT_WBITS >= NUM_INPUTS.

Ports:
- clk, input, 1: single clock for all logic.
- reset, input, 1: synchronous, active-high reset.
- enable_mask, input, NUM_INPUTS: per-input enable. Bit i=0 excludes input i from new arbitration; an in-flight packet still completes.
- S_AXIS_TDATA, input, NUM_INPUTS*DATA_WBITS: input i occupies bits [i*DATA_WBITS +: DATA_WBITS].
- S_AXIS_TKEEP, input, NUM_INPUTS*DATA_WBITS/8: packed the same way as TDATA.
- S_AXIS_TLAST, input, NUM_INPUTS: per-input last-beat flag.
- S_AXIS_TVALID, input, NUM_INPUTS: per-input valid.
- S_AXIS_TREADY, output, NUM_INPUTS: per-input ready.
- AXIS_TX_TDATA, output, DATA_WBITS: merged output data.
- AXIS_TX_TKEEP, output, DATA_WBITS/8: merged output keep.
- AXIS_TX_TLAST, output, 1: merged output last.
- AXIS_TX_TVALID, output, 1: merged output valid.
- AXIS_TX_TREADY, input, 1: ready from the MAC.
- grant_idx, output, GRANT_WBITS: index of the input currently or most recently granted.
- busy, output, 1: high while in state SEND.

Behaviour:
- State machine has two states, IDLE and SEND. Reset forces IDLE.
- Reset values:
  - grant_idx = NUM_INPUTS-1, so input 0 has first priority after reset.
  - busy = 0.
  - AXIS_TX_TVALID = 0 and S_AXIS_TREADY = 0 while reset is high.
- IDLE:
  - req = S_AXIS_TVALID & enable_mask.
  - If req != 0, select the first set bit searching upward from (grant_idx+1) mod NUM_INPUTS, wrapping.
  - Register the selection into grant_idx and go to SEND on the next edge.
  - Arbitration costs exactly 1 idle cycle per packet.
  - In IDLE, all S_AXIS_TREADY = 0 and AXIS_TX_TVALID = 0.
- SEND: the datapath is combinational pass-through with zero latency.
  - AXIS_TX_TDATA/TKEEP/TLAST/TVALID = the fields of input grant_idx.
  - S_AXIS_TREADY[grant_idx] = AXIS_TX_TREADY; all other TREADY bits = 0.
  - Outputs are don't-care when TVALID = 0; the bench checks them only when TVALID = 1.
- SEND -> IDLE on the edge where AXIS_TX_TVALID & AXIS_TX_TREADY & AXIS_TX_TLAST are all high. No other exit exists.
- Rules that hold in SEND:
  - Deasserting the granted input's TVALID mid-packet does not release the grant. TVALID gaps stall the output and no other input is admitted.
  - Clearing enable_mask for the granted input mid-packet has no effect until TLAST.
- Single-beat packet (TLAST on the first beat): IDLE -> SEND -> IDLE. Throughput is 1 beat per 2 cycles.
- Simultaneous requests: the pointer rotates after every packet, so with all inputs requesting continuously the grant order is 0,1,2,3,0,...
- Inputs at index >= NUM_INPUTS do not exist. Pointer wrap is modulo NUM_INPUTS, not 2**GRANT_WBITS.
- Reset mid-packet:
  - Returns to IDLE the cycle after reset is sampled and drops the grant.
  - The partial packet on AXIS_TX is abandoned; upstream reset is the system's responsibility.
- No packet-length limit and no TKEEP checking.

Optional Feature:
- Macro: RDMX_TX_ARB_PKT_COUNT_EN.
- When defined:
  - Adds output pkt_count, NUM_INPUTS*32 bits: per-input 32-bit count of packets completed, i.e. TLAST handshakes.
  - Counters wrap from 0xFFFFFFFF to 0.
  - Counters are cleared by reset.
  - A count increments on the cycle after the TLAST handshake.
- When not defined:
  - The port does not exist and no counter logic is built.
  - All other behaviour is identical.

Test Plan:
- Reset, then input 2 sends a 3-beat packet with TREADY held 1 -> 1 idle cycle, then 3 output beats with input-2 data. TLAST appears on beat 3, grant_idx = 2, busy returns to 0.
- All 4 inputs request 2-beat packets continuously, enable_mask = 0xF -> output packet order 0,1,2,3,0,1. Exactly 1 idle cycle between packets; no beat from a non-granted input appears.
- Input 1 granted with 4-beat packet, TREADY toggled 1,0,1,0,... and input 1 TVALID dropped for 2 cycles mid-packet, while input 3 requests -> input 3 is held off until input 1's TLAST handshake. Data order is preserved; input 3's TREADY stays 0 throughout.
- enable_mask = 0b1011 with all inputs requesting -> input 2 is never granted. Clearing bit 1 mid-packet on input 1 lets that packet finish, and input 1 is then skipped.
- Assert reset for 1 cycle at beat 2 of a 5-beat packet -> next cycle busy = 0, TVALID = 0, grant_idx = 3. The next request from input 0 is granted first.
- With RDMX_TX_ARB_PKT_COUNT_EN defined: input 0 sends 5 single-beat packets and input 3 sends 2 -> pkt_count reads 5,0,0,2. Preload to 0xFFFFFFFF via a forced state, then one more packet -> count reads 0.
